// File: rtl/mdu_multicycle.sv
// rtl/mdu_multicycle.sv - multi-cycle multiply/divide unit with HI/LO registers
// Define MDU_MADD_EN to enable MADD/MADDU (op 6/7); otherwise those ops are no-ops.
module mdu_multicycle #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXN = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXN > 1) ? $clog2(MAXN) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state, next_state;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   pend;
  logic                 pend_wr;

  logic                 accept, commit, wr_hi, wr_lo;
  logic [2*WIDTH-1:0]   prod_s, prod_u, res;
  logic                 res_ok, res_wr;
  logic [CW-1:0]        res_cnt;

  logic                 a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]     a_mag, b_mag, bs_safe, bu_safe;
  logic [WIDTH-1:0]     mq, mr, sq, sr, uq, ur;

  // Signed divide works on magnitudes so most-negative / -1 wraps to most-negative naturally.
  always_comb begin
    a_neg   = a[WIDTH-1];
    b_neg   = b[WIDTH-1];
    b_zero  = (b == '0);
    a_mag   = a_neg ? -a : a;
    b_mag   = b_neg ? -b : b;
    bs_safe = b_zero ? WIDTH'(1) : b_mag;
    bu_safe = b_zero ? WIDTH'(1) : b;
    mq      = a_mag / bs_safe;
    mr      = a_mag % bs_safe;
    sq      = (a_neg ^ b_neg) ? -mq : mq;
    sr      = a_neg ? -mr : mr;
    uq      = a / bu_safe;
    ur      = a % bu_safe;
    prod_s  = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    prod_u  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  end

  always_comb begin
    res     = prod_s;
    res_ok  = 1'b0;
    res_wr  = 1'b1;
    res_cnt = CW'(MULT_CYCLES - 1);
    case (op)
      3'd0: res_ok = 1'b1;
      3'd1: begin res = prod_u; res_ok = 1'b1; end
      3'd2: begin
        res = {sr, sq}; res_ok = 1'b1; res_wr = !b_zero; res_cnt = CW'(DIV_CYCLES - 1);
      end
      3'd3: begin
        res = {ur, uq}; res_ok = 1'b1; res_wr = !b_zero; res_cnt = CW'(DIV_CYCLES - 1);
      end
`ifdef MDU_MADD_EN
      3'd6: begin res = {hi, lo} + prod_s; res_ok = 1'b1; end
      3'd7: begin res = {hi, lo} + prod_u; res_ok = 1'b1; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    commit     = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    if (state == IDLE) begin
      if (start && !cancel) begin
        if (res_ok) begin
          accept     = 1'b1;
          next_state = RUN;
        end else if (op == 3'd4) begin
          wr_hi = 1'b1;
        end else if (op == 3'd5) begin
          wr_lo = 1'b1;
        end
      end
    end else begin
      if (cancel) begin
        next_state = IDLE;
      end else if (cnt == '0) begin
        commit     = 1'b1;
        next_state = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend    <= '0;
      pend_wr <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state <= next_state;
      done  <= commit;
      if (accept) begin
        cnt     <= res_cnt;
        pend    <= res;
        pend_wr <= res_wr;
      end else if (state == RUN) begin
        cnt <= (cancel || cnt == '0) ? '0 : cnt - CW'(1);
      end
      if (commit && pend_wr) begin
        hi <= pend[2*WIDTH-1:WIDTH];
        lo <= pend[WIDTH-1:0];
      end
      if (wr_hi) hi <= a;
      if (wr_lo) lo <= a;
    end
  end

  assign busy = (state == RUN);

endmodule
